// File: rtl/tcp_loopback_responder.sv
`default_nettype none
// ============================================================================
// Module  : tcp_loopback_responder
// Purpose : Stand-in for the Coyote TCP stack; answers ACCL TCP commands and
//           loops each transmitted payload back to the session's rx path.
// Rev     : 1.0  initial release
// ============================================================================
module tcp_loopback_responder #(
  parameter int LISTEN_SLOTS = 4,
  parameter int N_SESSIONS   = 8,
  parameter int MAX_BEATS    = 64,
  parameter int DATA_W       = 512
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  listen_req_valid,
  output logic                  listen_req_ready,
  input  logic [15:0]           listen_req_data,
  output logic                  listen_rsp_valid,
  input  logic                  listen_rsp_ready,
  output logic [7:0]            listen_rsp_data,
  input  logic                  open_req_valid,
  output logic                  open_req_ready,
  input  logic [47:0]           open_req_data,
  output logic                  open_rsp_valid,
  input  logic                  open_rsp_ready,
  output logic [71:0]           open_rsp_data,
  input  logic                  close_req_valid,
  output logic                  close_req_ready,
  input  logic [15:0]           close_req_data,
  output logic                  notify_valid,
  input  logic                  notify_ready,
  output logic [87:0]           notify_data,
  input  logic                  rd_pkg_valid,
  output logic                  rd_pkg_ready,
  input  logic [31:0]           rd_pkg_data,
  output logic                  rx_meta_valid,
  input  logic                  rx_meta_ready,
  output logic [15:0]           rx_meta_data,
  input  logic                  tx_meta_valid,
  output logic                  tx_meta_ready,
  input  logic [31:0]           tx_meta_data,
  output logic                  tx_stat_valid,
  input  logic                  tx_stat_ready,
  output logic [63:0]           tx_stat_data,
  input  logic                  tx_tvalid,
  output logic                  tx_tready,
  input  logic [DATA_W-1:0]     tx_tdata,
  input  logic [DATA_W/8-1:0]   tx_tkeep,
  input  logic                  tx_tlast,
  input  logic [5:0]            tx_tid,
  output logic                  rx_tvalid,
  input  logic                  rx_tready,
  output logic [DATA_W-1:0]     rx_tdata,
  output logic [DATA_W/8-1:0]   rx_tkeep,
  output logic                  rx_tlast,
  output logic [5:0]            rx_tid
);
  localparam int c_kw        = DATA_W / 8;
  localparam int c_buf_bytes = MAX_BEATS * c_kw;
  localparam int c_aw        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int c_cw        = $clog2(MAX_BEATS + 1);
  localparam int c_sw        = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1;
  localparam int c_lw        = (LISTEN_SLOTS > 1) ? $clog2(LISTEN_SLOTS) : 1;

  if (c_buf_bytes > 65535) begin : g_cfg_chk
    $error("MAX_BEATS*bytes-per-beat must fit in 16 bits");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_LISTEN_RSP, S_OPEN_RSP, S_CLOSE_NTF, S_TX_STAT,
    S_TX_DATA, S_NOTIFY, S_WAIT_RD, S_RX_META, S_RX_DATA
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_run;
  logic [LISTEN_SLOTS-1:0] r_lst_vld;
  logic [15:0]            r_lst_port [LISTEN_SLOTS];
  logic [N_SESSIONS-1:0]  r_sess_vld;
  logic                   r_listen_ok;
  logic [71:0]            r_open_data;
  logic [87:0]            r_notify_data;
  logic [63:0]            r_tx_stat_data;
  logic [1:0]             r_err;
  logic [15:0]            r_pend_sess, r_pend_len;
  logic [c_cw-1:0]        r_wr_cnt, r_rd_idx;
  logic [DATA_W+c_kw-1:0] r_mem [MAX_BEATS];
  logic [DATA_W+c_kw-1:0] r_rd_q;

  logic                   w_lst_hit, w_lst_free, w_open_hit, w_sess_free;
  logic [c_lw-1:0]        w_lst_slot;
  logic [c_sw-1:0]        w_sess_idx;
  logic                   w_close_ok, w_tx_sess_ok, w_rx_last, w_wr_en, w_rd_load;
  logic [1:0]             w_err;
  logic [c_cw-1:0]        w_rd_next;
  logic [c_aw-1:0]        w_rd_addr;
  logic                   w_unused_ok;

  assign w_unused_ok  = ^{tx_tid, rd_pkg_data[31:16]};
  assign w_close_ok   = (close_req_data < 16'(N_SESSIONS)) && r_sess_vld[close_req_data[c_sw-1:0]];
  assign w_tx_sess_ok = (tx_meta_data[15:0] < 16'(N_SESSIONS)) && r_sess_vld[tx_meta_data[c_sw-1:0]];
  assign w_rx_last    = (r_rd_idx == r_wr_cnt - c_cw'(1));
  assign w_rd_next    = r_rd_idx + c_cw'(1);
  assign w_wr_en      = (r_state == S_TX_DATA) && tx_tvalid && (r_wr_cnt < c_cw'(MAX_BEATS));
  assign w_rd_load    = ((r_state == S_RX_META) && rx_meta_ready) ||
                        ((r_state == S_RX_DATA) && rx_tready && !w_rx_last);
  assign w_rd_addr    = (r_state == S_RX_META) ? '0 : w_rd_next[c_aw-1:0];

  always_comb begin
    w_lst_hit  = 1'b0;
    w_lst_free = 1'b0;
    w_lst_slot = '0;
    w_open_hit = 1'b0;
    for (int i = LISTEN_SLOTS - 1; i >= 0; i--) begin
      if (!r_lst_vld[i]) begin
        w_lst_free = 1'b1;
        w_lst_slot = c_lw'(i);
      end
      if (r_lst_vld[i] && r_lst_port[i] == listen_req_data)     w_lst_hit  = 1'b1;
      if (r_lst_vld[i] && r_lst_port[i] == open_req_data[15:0]) w_open_hit = 1'b1;
    end
    w_sess_free = 1'b0;
    w_sess_idx  = '0;
    for (int i = N_SESSIONS - 1; i >= 0; i--) begin
      if (!r_sess_vld[i]) begin
        w_sess_free = 1'b1;
        w_sess_idx  = c_sw'(i);
      end
    end
    if (!w_tx_sess_ok)
      w_err = 2'd1;
    else if (tx_meta_data[31:16] == 16'd0 || tx_meta_data[31:16] > 16'(c_buf_bytes))
      w_err = 2'd2;
    else
      w_err = 2'd0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    listen_req_ready = 1'b0;
    open_req_ready   = 1'b0;
    close_req_ready  = 1'b0;
    tx_meta_ready    = 1'b0;
    rd_pkg_ready     = 1'b0;
    tx_tready        = 1'b0;
    listen_rsp_valid = 1'b0;
    open_rsp_valid   = 1'b0;
    notify_valid     = 1'b0;
    tx_stat_valid    = 1'b0;
    rx_meta_valid    = 1'b0;
    rx_tvalid        = 1'b0;
    case (r_state)
      S_IDLE: if (r_run) begin
        if (close_req_valid) begin
          close_req_ready = 1'b1;
          if (w_close_ok) w_state_nxt = S_CLOSE_NTF;
        end else if (listen_req_valid) begin
          listen_req_ready = 1'b1;
          w_state_nxt      = S_LISTEN_RSP;
        end else if (open_req_valid) begin
          open_req_ready = 1'b1;
          w_state_nxt    = S_OPEN_RSP;
        end else if (tx_meta_valid) begin
          tx_meta_ready = 1'b1;
          w_state_nxt   = S_TX_STAT;
        end
      end
      S_LISTEN_RSP: begin
        listen_rsp_valid = 1'b1;
        if (listen_rsp_ready) w_state_nxt = S_IDLE;
      end
      S_OPEN_RSP: begin
        open_rsp_valid = 1'b1;
        if (open_rsp_ready) w_state_nxt = S_IDLE;
      end
      S_CLOSE_NTF: begin
        notify_valid = 1'b1;
        if (notify_ready) w_state_nxt = S_IDLE;
      end
      S_TX_STAT: begin
        tx_stat_valid = 1'b1;
        if (tx_stat_ready) w_state_nxt = (r_err == 2'd0) ? S_TX_DATA : S_IDLE;
      end
      S_TX_DATA: begin
        tx_tready = 1'b1;
        if (tx_tvalid && tx_tlast) w_state_nxt = S_NOTIFY;
      end
      S_NOTIFY: begin
        notify_valid = 1'b1;
        if (notify_ready) w_state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        rd_pkg_ready = 1'b1;
        if (rd_pkg_valid && rd_pkg_data[15:0] == r_pend_sess) w_state_nxt = S_RX_META;
      end
      S_RX_META: begin
        rx_meta_valid = 1'b1;
        if (rx_meta_ready) w_state_nxt = S_RX_DATA;
      end
      S_RX_DATA: begin
        rx_tvalid = 1'b1;
        if (rx_tready && w_rx_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_run          <= 1'b0;
      r_lst_vld      <= '0;
      for (int i = 0; i < LISTEN_SLOTS; i++) r_lst_port[i] <= '0;
      r_sess_vld     <= '0;
      r_listen_ok    <= 1'b0;
      r_open_data    <= '0;
      r_notify_data  <= '0;
      r_tx_stat_data <= '0;
      r_err          <= '0;
      r_pend_sess    <= '0;
      r_pend_len     <= '0;
      r_wr_cnt       <= '0;
      r_rd_idx       <= '0;
    end else begin
      r_run <= 1'b1;
      if (close_req_valid && close_req_ready && w_close_ok) begin
        r_sess_vld[close_req_data[c_sw-1:0]] <= 1'b0;
        r_notify_data <= {7'd0, 1'b1, 48'd0, 16'd0, close_req_data};
      end
      if (listen_req_valid && listen_req_ready) begin
        r_listen_ok <= !w_lst_hit && w_lst_free;
        if (!w_lst_hit && w_lst_free) begin
          r_lst_vld[w_lst_slot]  <= 1'b1;
          r_lst_port[w_lst_slot] <= listen_req_data;
        end
      end
      if (open_req_valid && open_req_ready) begin
        if (w_open_hit && w_sess_free) begin
          r_sess_vld[w_sess_idx] <= 1'b1;
          r_open_data <= {7'd0, open_req_data[15:0], open_req_data[47:16], 1'b1, 16'(w_sess_idx)};
        end else begin
          r_open_data <= {7'd0, open_req_data[15:0], open_req_data[47:16], 1'b0, 16'd0};
        end
      end
      if (tx_meta_valid && tx_meta_ready) begin
        r_pend_sess    <= tx_meta_data[15:0];
        r_pend_len     <= tx_meta_data[31:16];
        r_err          <= w_err;
        r_tx_stat_data <= {w_err, 30'(c_buf_bytes), tx_meta_data};
      end
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + c_cw'(1);
      if (r_state == S_TX_DATA && tx_tvalid && tx_tlast)
        r_notify_data <= {7'd0, 1'b0, 48'd0, r_pend_len, r_pend_sess};
      if (r_state == S_RX_META && rx_meta_ready) r_rd_idx <= '0;
      // Presented beat index; the next beat is prefetched on each handshake.
      if (r_state == S_RX_DATA && rx_tready) begin
        if (w_rx_last) begin
          r_wr_cnt <= '0;
          r_rd_idx <= '0;
        end else begin
          r_rd_idx <= w_rd_next;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_wr_en)   r_mem[r_wr_cnt[c_aw-1:0]] <= {tx_tkeep, tx_tdata};
    if (w_rd_load) r_rd_q <= r_mem[w_rd_addr];
  end

  assign listen_rsp_data = {7'd0, r_listen_ok};
  assign open_rsp_data   = r_open_data;
  assign notify_data     = r_notify_data;
  assign tx_stat_data    = r_tx_stat_data;
  assign rx_meta_data    = r_pend_sess;
  assign rx_tdata        = r_rd_q[DATA_W-1:0];
  assign rx_tkeep        = r_rd_q[DATA_W +: c_kw];
  assign rx_tlast        = w_rx_last;
  assign rx_tid          = r_pend_sess[5:0];
endmodule
`default_nettype wire

// File: tb/tb_tcp_loopback_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tcp_loopback_responder
// Purpose : Directed self-checking bench for tcp_loopback_responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tcp_loopback_responder;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic listen_req_valid, listen_req_ready, listen_rsp_valid, listen_rsp_ready;
  logic [15:0] listen_req_data;
  logic [7:0]  listen_rsp_data;
  logic open_req_valid, open_req_ready, open_rsp_valid, open_rsp_ready;
  logic [47:0] open_req_data;
  logic [71:0] open_rsp_data;
  logic close_req_valid, close_req_ready, notify_valid, notify_ready;
  logic [15:0] close_req_data;
  logic [87:0] notify_data;
  logic rd_pkg_valid, rd_pkg_ready, rx_meta_valid, rx_meta_ready;
  logic [31:0] rd_pkg_data;
  logic [15:0] rx_meta_data;
  logic tx_meta_valid, tx_meta_ready, tx_stat_valid, tx_stat_ready;
  logic [31:0] tx_meta_data;
  logic [63:0] tx_stat_data;
  logic tx_tvalid, tx_tready, tx_tlast, rx_tvalid, rx_tready, rx_tlast;
  logic [511:0] tx_tdata, rx_tdata;
  logic [63:0]  tx_tkeep, rx_tkeep;
  logic [5:0]   tx_tid, rx_tid;

  tcp_loopback_responder dut (
    .aclk(aclk), .areset(areset),
    .listen_req_valid(listen_req_valid), .listen_req_ready(listen_req_ready), .listen_req_data(listen_req_data),
    .listen_rsp_valid(listen_rsp_valid), .listen_rsp_ready(listen_rsp_ready), .listen_rsp_data(listen_rsp_data),
    .open_req_valid(open_req_valid), .open_req_ready(open_req_ready), .open_req_data(open_req_data),
    .open_rsp_valid(open_rsp_valid), .open_rsp_ready(open_rsp_ready), .open_rsp_data(open_rsp_data),
    .close_req_valid(close_req_valid), .close_req_ready(close_req_ready), .close_req_data(close_req_data),
    .notify_valid(notify_valid), .notify_ready(notify_ready), .notify_data(notify_data),
    .rd_pkg_valid(rd_pkg_valid), .rd_pkg_ready(rd_pkg_ready), .rd_pkg_data(rd_pkg_data),
    .rx_meta_valid(rx_meta_valid), .rx_meta_ready(rx_meta_ready), .rx_meta_data(rx_meta_data),
    .tx_meta_valid(tx_meta_valid), .tx_meta_ready(tx_meta_ready), .tx_meta_data(tx_meta_data),
    .tx_stat_valid(tx_stat_valid), .tx_stat_ready(tx_stat_ready), .tx_stat_data(tx_stat_data),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast), .tx_tid(tx_tid),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast), .rx_tid(rx_tid)
  );

  int n_checks = 0;
  int n_pass   = 0;
  localparam logic [31:0] c_ip = 32'h0A000001;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tmo(input string tag);
    n_checks++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic logic [511:0] beat(input int k);
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[w*32 +: 32] = {8'(k), 8'(w), 16'hA5C3};
    return b;
  endfunction

  task automatic do_listen(input logic [15:0] port, output logic [7:0] rsp);
    listen_req_data = port; listen_req_valid = 1'b1; #1;
    for (int i = 0; i < 50 && !listen_req_ready; i++) step();
    if (!listen_req_ready) tmo("listen_req");
    step(); listen_req_valid = 1'b0;
    for (int i = 0; i < 50 && !listen_rsp_valid; i++) step();
    if (!listen_rsp_valid) tmo("listen_rsp");
    rsp = listen_rsp_data; listen_rsp_ready = 1'b1; step(); listen_rsp_ready = 1'b0;
  endtask

  task automatic do_open(input logic [15:0] port, output logic [71:0] rsp);
    open_req_data = {c_ip, port}; open_req_valid = 1'b1; #1;
    for (int i = 0; i < 50 && !open_req_ready; i++) step();
    if (!open_req_ready) tmo("open_req");
    step(); open_req_valid = 1'b0;
    for (int i = 0; i < 50 && !open_rsp_valid; i++) step();
    if (!open_rsp_valid) tmo("open_rsp");
    rsp = open_rsp_data; open_rsp_ready = 1'b1; step(); open_rsp_ready = 1'b0;
  endtask

  task automatic send_close(input logic [15:0] s);
    close_req_data = s; close_req_valid = 1'b1; #1;
    for (int i = 0; i < 50 && !close_req_ready; i++) step();
    if (!close_req_ready) tmo("close_req");
    step(); close_req_valid = 1'b0;
  endtask

  task automatic get_notify(output logic [87:0] d);
    for (int i = 0; i < 50 && !notify_valid; i++) step();
    if (!notify_valid) tmo("notify");
    d = notify_data; notify_ready = 1'b1; step(); notify_ready = 1'b0;
  endtask

  task automatic do_txmeta(input logic [15:0] s, input logic [15:0] len, output logic [63:0] st);
    tx_meta_data = {len, s}; tx_meta_valid = 1'b1; #1;
    for (int i = 0; i < 50 && !tx_meta_ready; i++) step();
    if (!tx_meta_ready) tmo("tx_meta");
    step(); tx_meta_valid = 1'b0;
    for (int i = 0; i < 50 && !tx_stat_valid; i++) step();
    if (!tx_stat_valid) tmo("tx_stat");
    st = tx_stat_data; tx_stat_ready = 1'b1; step(); tx_stat_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    tx_tdata = d; tx_tkeep = k; tx_tlast = l; tx_tid = 6'h2A; tx_tvalid = 1'b1; #1;
    for (int i = 0; i < 50 && !tx_tready; i++) step();
    if (!tx_tready) tmo("tx_beat");
    step(); tx_tvalid = 1'b0; tx_tlast = 1'b0;
  endtask

  task automatic send_rd(input logic [15:0] s, input logic [15:0] len);
    rd_pkg_data = {len, s}; rd_pkg_valid = 1'b1; #1;
    for (int i = 0; i < 50 && !rd_pkg_ready; i++) step();
    if (!rd_pkg_ready) tmo("rd_pkg");
    step(); rd_pkg_valid = 1'b0;
  endtask

  task automatic get_rxmeta(output logic [15:0] d);
    for (int i = 0; i < 50 && !rx_meta_valid; i++) step();
    if (!rx_meta_valid) tmo("rx_meta");
    d = rx_meta_data; rx_meta_ready = 1'b1; step(); rx_meta_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  lr;
    logic [71:0] orsp;
    logic [87:0] nt;
    logic [63:0] st;
    logic [15:0] rm;
    int k;
    areset = 1'b1;
    {listen_req_valid, listen_rsp_ready, open_req_valid, open_rsp_ready} = '0;
    {close_req_valid, notify_ready, rd_pkg_valid, rx_meta_ready} = '0;
    {tx_meta_valid, tx_stat_ready, tx_tvalid, tx_tlast, rx_tready} = '0;
    listen_req_data = 16'd5001; open_req_data = '0; close_req_data = '0;
    rd_pkg_data = '0; tx_meta_data = '0; tx_tdata = '0; tx_tkeep = '0; tx_tid = '0;
    listen_req_valid = 1'b1;
    step(); step(); step();
    chk("rst_valids", {listen_rsp_valid, open_rsp_valid, notify_valid, tx_stat_valid,
                       rx_meta_valid, rx_tvalid}, 6'b0);
    chk("rst_ready", listen_req_ready, 1'b0);
    areset = 1'b0; #1;
    chk("ready_at_deassert", listen_req_ready, 1'b0);
    listen_req_valid = 1'b0;

    // listen table: duplicate and full cases
    do_listen(16'd5001, lr); chk("listen_5001", lr, 8'd1);
    do_listen(16'd5001, lr); chk("listen_dup", lr, 8'd0);
    do_listen(16'd5002, lr); chk("listen_5002", lr, 8'd1);
    do_listen(16'd5003, lr); chk("listen_5003", lr, 8'd1);
    do_listen(16'd5004, lr); chk("listen_5004", lr, 8'd1);
    do_listen(16'd5005, lr); chk("listen_full", lr, 8'd0);

    do_open(16'd5001, orsp); chk("open_s0", orsp, {7'd0, 16'd5001, c_ip, 1'b1, 16'd0});
    do_open(16'd5001, orsp); chk("open_s1", orsp, {7'd0, 16'd5001, c_ip, 1'b1, 16'd1});
    do_open(16'd5001, orsp); chk("open_s2", orsp, {7'd0, 16'd5001, c_ip, 1'b1, 16'd2});
    do_open(16'd6000, orsp); chk("open_fail", orsp[16:0], 17'd0);

    // loopback of a two-beat payload on session 0
    do_txmeta(16'd0, 16'd128, st); chk("txstat_ok", st, {2'd0, 30'd4096, 16'd128, 16'd0});
    send_beat(beat(0), {64{1'b1}}, 1'b0);
    send_beat(beat(1), {64{1'b1}}, 1'b1);
    get_notify(nt); chk("notify_tx", nt, {7'd0, 1'b0, 48'd0, 16'd128, 16'd0});
    send_rd(16'd0, 16'd128);
    get_rxmeta(rm); chk("rxmeta_s0", rm, 16'd0);
    rx_tready = 1'b1; #1;
    chk("rx0_valid", rx_tvalid, 1'b1);
    chk("rx0_data", rx_tdata, beat(0));
    chk("rx0_last", rx_tlast, 1'b0);
    chk("rx0_tid", rx_tid, 6'd0);
    step();
    chk("rx1_valid", rx_tvalid, 1'b1);
    chk("rx1_data", rx_tdata, beat(1));
    chk("rx1_last", rx_tlast, 1'b1);
    chk("rx1_keep", rx_tkeep, {64{1'b1}});
    step(); rx_tready = 1'b0;
    chk("rx_done", rx_tvalid, 1'b0);

    // tx_meta error codes
    do_txmeta(16'd5, 16'd64, st); chk("txstat_nosess", st, {2'd1, 30'd4096, 16'd64, 16'd5});
    step();
    chk("txready_after_err", tx_tready, 1'b0);
    do_txmeta(16'd0, 16'd5000, st); chk("txstat_long", st, {2'd2, 30'd4096, 16'd5000, 16'd0});
    do_txmeta(16'd0, 16'd4097, st); chk("txstat_4097", st, {2'd2, 30'd4096, 16'd4097, 16'd0});
    do_txmeta(16'd0, 16'd0, st);    chk("txstat_zero", st, {2'd2, 30'd4096, 16'd0, 16'd0});

    // close wins over simultaneous listen/open/tx_meta
    close_req_data = 16'd1; listen_req_data = 16'd5005;
    open_req_data = {c_ip, 16'd5001}; tx_meta_data = {16'd64, 16'd0};
    {close_req_valid, listen_req_valid, open_req_valid, tx_meta_valid} = 4'b1111; #1;
    chk("prio_readies", {close_req_ready, listen_req_ready, open_req_ready, tx_meta_ready}, 4'b1000);
    step();
    {close_req_valid, listen_req_valid, open_req_valid, tx_meta_valid} = 4'b0000;
    get_notify(nt); chk("notify_close", nt, {7'd0, 1'b1, 48'd0, 16'd0, 16'd1});
    send_close(16'd7); step(); step();
    chk("close_invalid_silent", notify_valid, 1'b0);
    do_open(16'd5001, orsp); chk("open_reuse_s1", orsp, {7'd0, 16'd5001, c_ip, 1'b1, 16'd1});

    // five beats on session 1, random rx_tready, reset mid-replay
    do_txmeta(16'd1, 16'd320, st); chk("txstat_s1", st, {2'd0, 30'd4096, 16'd320, 16'd1});
    for (int b = 0; b < 5; b++) send_beat(beat(b + 8), (b == 4) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}}, b == 4);
    get_notify(nt); chk("notify_s1", nt, {7'd0, 1'b0, 48'd0, 16'd320, 16'd1});
    send_rd(16'd3, 16'd320);
    chk("rd_mismatch_rxmeta", rx_meta_valid, 1'b0);
    chk("rd_mismatch_stay", rd_pkg_ready, 1'b1);
    send_rd(16'd1, 16'd320);
    get_rxmeta(rm); chk("rxmeta_s1", rm, 16'd1);
    k = 0;
    for (int c = 0; c < 300 && k < 3; c++) begin
      rx_tready = 1'($urandom_range(0, 1)); #1;
      if (rx_tvalid && rx_tready) begin
        chk("rxr_data", rx_tdata, beat(k + 8));
        chk("rxr_tid", rx_tid, 6'd1);
        chk("rxr_last", rx_tlast, 1'b0);
        k++;
      end
      step();
    end
    if (k < 3) tmo("rx_random");
    rx_tready = 1'b0;
    chk("pre_reset_rxvalid", rx_tvalid, 1'b1);
    areset = 1'b1; #1;
    chk("reset_valids", {listen_rsp_valid, open_rsp_valid, notify_valid, tx_stat_valid,
                         rx_meta_valid, rx_tvalid}, 6'b0);
    step(); areset = 1'b0;
    do_listen(16'd5001, lr); chk("listen_after_rst", lr, 8'd1);
    do_open(16'd5001, orsp); chk("open_after_rst", orsp, {7'd0, 16'd5001, c_ip, 1'b1, 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
